// File: rtl/rfa_pkg.sv
// Shared register-file arbiter definitions: VGPR geometry and the bit positions
// of each requester inside the arbiter's serviced vector.
package rfa_pkg;

   localparam int VGPR_ADDR_WIDTH = 10;
   localparam int WFID_WIDTH      = 6;
   localparam int LANES           = 64;
   localparam int LANE_BITS       = 32;

   localparam int SVC_SIMD0 = 0;
   localparam int SVC_SIMD1 = 1;
   localparam int SVC_SIMD2 = 2;
   localparam int SVC_SIMD3 = 3;
   localparam int SVC_SIMF0 = 4;
   localparam int SVC_SIMF1 = 5;
   localparam int SVC_SIMF2 = 6;
   localparam int SVC_SIMF3 = 7;
   localparam int SVC_LSU   = 8;
   localparam int SVC_SALU  = 9;
   localparam int SVC_COUNT = 10;

endpackage

// File: rtl/wb_fifo_mem.sv
// Write-back queue storage: a plain register array with one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset.
module wb_fifo_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/simd_wb_queue.sv
// FIFO of completed SIMD/SIMF results waiting for a register-file write slot.
// The head entry is offered to the arbiter; a grant pops it and pulses retire.
module simd_wb_queue
   import rfa_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = rfa_pkg::VGPR_ADDR_WIDTH,
   parameter int DATA_WIDTH = rfa_pkg::LANES * rfa_pkg::LANE_BITS,
   parameter int MASK_WIDTH = rfa_pkg::LANES,
   parameter int WFID_WIDTH = rfa_pkg::WFID_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fu_wr_en,
   input  logic [ADDR_WIDTH-1:0] fu_wr_addr,
   input  logic [DATA_WIDTH-1:0] fu_wr_data,
   input  logic [MASK_WIDTH-1:0] fu_wr_mask,
   input  logic [WFID_WIDTH-1:0] fu_wr_wfid,
   output logic                  fu_stall,
   output logic                  queue_entry_valid,
   input  logic                  queue_entry_serviced,
   output logic [ADDR_WIDTH-1:0] vgpr_wr_addr,
   output logic [DATA_WIDTH-1:0] vgpr_wr_data,
   output logic [MASK_WIDTH-1:0] vgpr_wr_mask,
   output logic                  retire_valid,
   output logic [WFID_WIDTH-1:0] retire_wfid,
   output logic                  err_overflow,
   output logic                  err_spurious
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int ENTRY_W = WFID_WIDTH + MASK_WIDTH + DATA_WIDTH + ADDR_WIDTH;

   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head_entry;
   logic [WFID_WIDTH-1:0] head_wfid;

   assign full  = (count == CNT_MAX);
   assign empty = (count == '0);

   // Full/empty are judged on the registered count, so a same-cycle pop never
   // makes room for a push arriving at a full queue.
   assign push = fu_wr_en && !full;
   assign pop  = queue_entry_serviced && !empty;

   assign fu_stall          = full;
   assign queue_entry_valid = !empty;

   assign wr_entry = {fu_wr_wfid, fu_wr_mask, fu_wr_data, fu_wr_addr};

   wb_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_idx  (wr_ptr),
      .wr_data (wr_entry),
      .rd_idx  (rd_ptr),
      .rd_data (head_entry)
   );

   assign {head_wfid, vgpr_wr_mask, vgpr_wr_data, vgpr_wr_addr} = head_entry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         retire_valid <= 1'b0;
         retire_wfid  <= '0;
         err_overflow <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase

         // Retire reports the wavefront of the entry that left at this edge.
         retire_valid <= pop;
         if (pop) begin
            retire_wfid <= head_wfid;
         end

         if (fu_wr_en && full) begin
            err_overflow <= 1'b1;
         end
         if (queue_entry_serviced && empty) begin
            err_spurious <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_simd_wb_queue.sv
// Directed bench for simd_wb_queue: hand-computed head/retire/flag values
// checked with immediate assertions after each clock edge.
module tb_simd_wb_queue;

   localparam int AW = 10;
   localparam int DW = 2048;
   localparam int MW = 64;
   localparam int WW = 6;

   logic          clk;
   logic          rst;
   logic          fu_wr_en;
   logic [AW-1:0] fu_wr_addr;
   logic [DW-1:0] fu_wr_data;
   logic [MW-1:0] fu_wr_mask;
   logic [WW-1:0] fu_wr_wfid;
   logic          fu_stall;
   logic          queue_entry_valid;
   logic          queue_entry_serviced;
   logic [AW-1:0] vgpr_wr_addr;
   logic [DW-1:0] vgpr_wr_data;
   logic [MW-1:0] vgpr_wr_mask;
   logic          retire_valid;
   logic [WW-1:0] retire_wfid;
   logic          err_overflow;
   logic          err_spurious;

   int total = 0;
   int bad   = 0;

   simd_wb_queue dut (
      .clk                  (clk),
      .rst                  (rst),
      .fu_wr_en             (fu_wr_en),
      .fu_wr_addr           (fu_wr_addr),
      .fu_wr_data           (fu_wr_data),
      .fu_wr_mask           (fu_wr_mask),
      .fu_wr_wfid           (fu_wr_wfid),
      .fu_stall             (fu_stall),
      .queue_entry_valid    (queue_entry_valid),
      .queue_entry_serviced (queue_entry_serviced),
      .vgpr_wr_addr         (vgpr_wr_addr),
      .vgpr_wr_data         (vgpr_wr_data),
      .vgpr_wr_mask         (vgpr_wr_mask),
      .retire_valid         (retire_valid),
      .retire_wfid          (retire_wfid),
      .err_overflow         (err_overflow),
      .err_spurious         (err_spurious)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
      return {64{~a, 12'h5A5, a}};
   endfunction

   function automatic logic [MW-1:0] mk_mask(input logic [AW-1:0] a);
      return {a, 44'h0, a} ^ 64'hF0F0_0000_0000_0F0F;
   endfunction

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Head address plus full data/mask comparison against the pattern pushed for addr.
   task automatic check_head(input string tag, input logic [AW-1:0] a);
      check_output({tag, "_valid"}, 64'(queue_entry_valid), 64'd1);
      check_output({tag, "_addr"}, 64'(vgpr_wr_addr), 64'(a));
      check_output({tag, "_data"}, 64'(vgpr_wr_data === mk_data(a)), 64'd1);
      check_output({tag, "_mask"}, vgpr_wr_mask, mk_mask(a));
   endtask

   task automatic apply_stimulus(input logic en, input logic [AW-1:0] a, input logic [WW-1:0] w,
                                 input logic svc);
      fu_wr_en             = en;
      fu_wr_addr           = a;
      fu_wr_data           = mk_data(a);
      fu_wr_mask           = mk_mask(a);
      fu_wr_wfid           = w;
      queue_entry_serviced = svc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      apply_stimulus(1'b1, 10'h005, 6'd3, 1'b0);
      #2 rst = 1'b1;

      // 1: reset held with push requested
      step();
      step();
      check_output("rst_valid", 64'(queue_entry_valid), 64'd0);
      check_output("rst_stall", 64'(fu_stall), 64'd0);
      check_output("rst_retire", 64'(retire_valid), 64'd0);
      check_output("rst_retire_wfid", 64'(retire_wfid), 64'd0);
      check_output("rst_err_ovf", 64'(err_overflow), 64'd0);
      check_output("rst_err_spur", 64'(err_spurious), 64'd0);
      rst = 1'b0;
      #1;
      check_output("rel_valid", 64'(queue_entry_valid), 64'd0);
      step();
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b0);
      check_head("t1_head", 10'h005);
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b1);
      step();
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b0);
      check_output("t1_empty", 64'(queue_entry_valid), 64'd0);
      check_output("t1_retire", 64'(retire_valid), 64'd1);
      check_output("t1_retire_wfid", 64'(retire_wfid), 64'd3);
      step();
      check_output("t1_retire_end", 64'(retire_valid), 64'd0);

      // 2: fill, overflow, drain in order
      for (int i = 1; i <= 4; i++) begin
         apply_stimulus(1'b1, AW'(i), WW'(10 + i), 1'b0);
         step();
         check_output($sformatf("t2_stall%0d", i), 64'(fu_stall), (i == 4) ? 64'd1 : 64'd0);
      end
      apply_stimulus(1'b1, 10'h009, 6'd9, 1'b0);
      step();
      check_output("t2_err_ovf", 64'(err_overflow), 64'd1);
      check_output("t2_stall_hold", 64'(fu_stall), 64'd1);
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         check_head($sformatf("t2_head%0d", i), AW'(i));
         step();
         check_output($sformatf("t2_retire%0d", i), 64'(retire_valid), 64'd1);
         check_output($sformatf("t2_rwfid%0d", i), 64'(retire_wfid), 64'(10 + i));
      end
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b0);
      check_output("t2_empty", 64'(queue_entry_valid), 64'd0);
      step();
      check_output("t2_retire_end", 64'(retire_valid), 64'd0);

      // 3: push and service together while full
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b1, AW'(32 + i), WW'(20 + i), 1'b0);
         step();
      end
      apply_stimulus(1'b1, 10'h02F, 6'd47, 1'b1);
      step();
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b0);
      check_output("t3_stall", 64'(fu_stall), 64'd0);
      check_output("t3_retire_wfid", 64'(retire_wfid), 64'd20);
      check_output("t3_err_ovf", 64'(err_overflow), 64'd1);
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         check_head($sformatf("t3_head%0d", k), AW'(32 + k));
         step();
      end
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b0);
      check_output("t3_empty", 64'(queue_entry_valid), 64'd0);

      // 4: steady push+pop with two entries resident, wrapping pointers
      apply_stimulus(1'b1, 10'h040, 6'h00, 1'b0);
      step();
      apply_stimulus(1'b1, 10'h041, 6'h01, 1'b0);
      step();
      for (int k = 0; k < 10; k++) begin
         apply_stimulus(1'b1, AW'(66 + k), WW'(2 + k), 1'b1);
         check_head($sformatf("t4_head%0d", k), AW'(64 + k));
         check_output($sformatf("t4_stall%0d", k), 64'(fu_stall), 64'd0);
         step();
         check_output($sformatf("t4_rwfid%0d", k), 64'(retire_wfid), 64'(k));
      end
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b1);
      check_head("t4_left0", 10'h04A);
      step();
      check_head("t4_left1", 10'h04B);
      step();
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b0);
      check_output("t4_empty", 64'(queue_entry_valid), 64'd0);
      step();

      // 5: spurious service while empty
      check_output("t5_spur_before", 64'(err_spurious), 64'd0);
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b1);
      step();
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b0);
      check_output("t5_spur", 64'(err_spurious), 64'd1);
      check_output("t5_retire", 64'(retire_valid), 64'd0);
      check_output("t5_valid", 64'(queue_entry_valid), 64'd0);
      apply_stimulus(1'b1, 10'h055, 6'd5, 1'b0);
      step();
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b1);
      check_head("t5_head", 10'h055);
      step();
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b0);
      check_output("t5_rwfid", 64'(retire_wfid), 64'd5);

      // 6: asynchronous reset with entries queued and a retire pending
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, AW'(96 + i), WW'(30 + i), 1'b0);
         step();
      end
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b1);
      step();
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b0);
      check_output("t6_pre_retire", 64'(retire_valid), 64'd1);
      check_output("t6_pre_valid", 64'(queue_entry_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check_output("t6_valid", 64'(queue_entry_valid), 64'd0);
      check_output("t6_retire", 64'(retire_valid), 64'd0);
      check_output("t6_err_ovf", 64'(err_overflow), 64'd0);
      check_output("t6_err_spur", 64'(err_spurious), 64'd0);
      step();
      rst = 1'b0;
      step();
      check_output("t6_empty", 64'(queue_entry_valid), 64'd0);
      apply_stimulus(1'b1, 10'h070, 6'd7, 1'b0);
      step();
      apply_stimulus(1'b0, 10'h000, 6'd0, 1'b0);
      check_head("t6_head", 10'h070);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
